// File: rtl/shifter_pkg.sv
// Shared definitions for the shifter_n block: op-code constants, FSM state
// encoding and a helper that classifies shift op-codes.
package shifter_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_LSL  = 3'b010;
  localparam logic [2:0] OP_LSR  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // True for the five op-codes that move bits (LSL, LSR, ASR, ROL, ROR).
  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR) ||
           (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/shifter_n_unit.sv
// Combinational datapath for shifter_n: next d_out value from op, amount and
// current operand. With SHIFTER_N_BARREL_EN defined it shifts by the full
// amount; otherwise any non-zero amount performs a single 1-bit step.
module shifter_n_unit
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [2:0]       op,
  input  logic [SHW-1:0]   amt,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] lsl_val;
  logic [WIDTH-1:0] lsr_val;
  logic [WIDTH-1:0] asr_val;
  logic [WIDTH-1:0] rol_val;
  logic [WIDTH-1:0] ror_val;

`ifdef SHIFTER_N_BARREL_EN
  logic [2*WIDTH-1:0] rol_ext;
  logic [2*WIDTH-1:0] ror_ext;

  // Rotations come from shifting a doubled copy of the operand.
  assign rol_ext = {operand, operand} << amt;
  assign ror_ext = {operand, operand} >> amt;

  assign lsl_val = operand << amt;
  assign lsr_val = operand >> amt;
  assign asr_val = $signed(operand) >>> amt;
  assign rol_val = rol_ext[2*WIDTH-1:WIDTH];
  assign ror_val = ror_ext[WIDTH-1:0];
`else
  // One bit per step; a zero amount leaves the operand untouched.
  assign lsl_val = (amt == '0) ? operand : {operand[WIDTH-2:0], 1'b0};
  assign lsr_val = (amt == '0) ? operand : {1'b0, operand[WIDTH-1:1]};
  assign asr_val = (amt == '0) ? operand : {operand[WIDTH-1], operand[WIDTH-1:1]};
  assign rol_val = (amt == '0) ? operand : {operand[WIDTH-2:0], operand[WIDTH-1]};
  assign ror_val = (amt == '0) ? operand : {operand[0], operand[WIDTH-1:1]};
`endif

  // Select the result for the requested op; NOP and reserved hold the operand.
  always_comb begin
    result = operand;
    case (op)
      OP_LOAD: result = load_data;
      OP_LSL:  result = lsl_val;
      OP_LSR:  result = lsr_val;
      OP_ASR:  result = asr_val;
      OP_ROL:  result = rol_val;
      OP_ROR:  result = ror_val;
      default: result = operand;
    endcase
  end

endmodule

// File: rtl/shifter_n.sv
// shifter_n: registered shift/rotate unit operating on its own result register.
// Default build shifts iteratively one bit per clock under an IDLE/RUN FSM;
// defining SHIFTER_N_BARREL_EN makes every op single-cycle and removes RUN.
module shifter_n
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] d_out_reg;
  logic             done_reg;
  logic [2:0]       unit_op;
  logic [SHW-1:0]   unit_amt;
  logic [WIDTH-1:0] unit_result;

  shifter_n_unit #(.WIDTH(WIDTH)) u_unit (
    .op        (unit_op),
    .amt       (unit_amt),
    .operand   (d_out_reg),
    .load_data (d_in),
    .result    (unit_result)
  );

`ifdef SHIFTER_N_BARREL_EN
  assign unit_op  = op;
  assign unit_amt = shamt;

  // Every accepted request completes at its own edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_out_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= start;
      if (start) begin
        d_out_reg <= unit_result;
      end
    end
  end

  assign busy = 1'b0;
`else
  state_t           state_reg, state_next;
  logic [SHW-1:0]   cnt_reg, cnt_next;
  logic [2:0]       op_reg, op_next;
  logic [WIDTH-1:0] d_out_next;
  logic             done_next;

  // State, counter, latched op and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      op_reg    <= OP_NOP;
      d_out_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      d_out_reg <= d_out_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic: accept in IDLE, step one bit per cycle in RUN.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    d_out_next = d_out_reg;
    done_next  = 1'b0;
    unit_op    = op;
    unit_amt   = shamt;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (is_shift(op) && (shamt != '0)) begin
            // Result stays put at acceptance; the steps follow in RUN.
            state_next = ST_RUN;
            op_next    = op;
            cnt_next   = shamt;
          end else begin
            d_out_next = unit_result;
            done_next  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // Latched op drives the datapath so input changes cannot disturb it.
        unit_op    = op_reg;
        unit_amt   = SHW'(1);
        d_out_next = unit_result;
        cnt_next   = cnt_reg - SHW'(1);
        if (cnt_reg == SHW'(1)) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state_reg == ST_RUN);
`endif

  assign d_out = d_out_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_shifter_n.sv
// Self-checking bench for shifter_n (WIDTH=8). Expected results are pushed to a
// scoreboard queue when a request is driven and popped when done is seen.
module tb_shifter_n;

  localparam int WIDTH = 8;
  localparam int SHW   = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [2:0]       op;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out;
  logic             busy;
  logic             done;

  int               tests = 0;
  int               fails = 0;
  logic [7:0]       exp_q[$];
  logic [7:0]       cur = 8'h00;

  always #5 clk = ~clk;

  shifter_n #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .shamt (shamt),
    .d_in  (d_in),
    .d_out (d_out),
    .busy  (busy),
    .done  (done)
  );

  // Reference: apply the op bit by bit.
  function automatic logic [7:0] model(input logic [2:0] o, input int s,
                                       input logic [7:0] v, input logic [7:0] ld);
    logic [7:0] r;
    r = v;
    case (o)
      3'b001: r = ld;
      3'b010: for (int i = 0; i < s; i++) r = {r[6:0], 1'b0};
      3'b011: for (int i = 0; i < s; i++) r = {1'b0, r[7:1]};
      3'b100: for (int i = 0; i < s; i++) r = {r[7], r[7:1]};
      3'b101: for (int i = 0; i < s; i++) r = {r[6:0], r[7]};
      3'b110: for (int i = 0; i < s; i++) r = {r[0], r[7:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one request (optionally holding a junk LOAD 0x00 during RUN) and
  // follow it to its done pulse; leaves time in the done cycle.
  task automatic run_op(input string tag, input logic [2:0] o, input int s,
                        input logic [7:0] d, input logic [7:0] exp, input bit junk);
    int k;
    int n;
    logic [7:0] start_val;
    logic [7:0] got;
    start_val = cur;
    exp_q.push_back(exp);
`ifdef SHIFTER_N_BARREL_EN
    k = 0;
`else
    k = (o inside {[3'd2:3'd6]}) ? s : 0;
`endif
    start = 1'b1; op = o; shamt = SHW'(s); d_in = d;
    @(posedge clk); #1;
    if (junk) begin
      op = 3'b001; d_in = 8'h00; shamt = '0;
    end else begin
      start = 1'b0;
    end
    n = 0;
    while (busy && n < 64) begin
      check({tag, " step"}, d_out, model(o, n, start_val, d));
      n++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check({tag, " busy_cycles"}, n, k);
    check({tag, " done"}, done, 1'b1);
    got = exp_q.pop_front();
    check({tag, " d_out"}, d_out, got);
    $display("[TB] %s op=%0d shamt=%0d d_out=0x%02h busy_cycles=%0d", tag, o, s, d_out, n);
    cur = got;
  endtask

  // One cycle with no request: done drops and d_out holds.
  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    check({tag, " done_low"}, done, 1'b0);
    check({tag, " busy_low"}, busy, 1'b0);
    check({tag, " hold"}, d_out, cur);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] ro;
    int rs;
    logic [7:0] rd;
    reset = 1'b1; start = 1'b1; op = 3'b001; shamt = '0; d_in = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("reset d_out", d_out, 8'h00);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    reset = 1'b0; start = 1'b0;

    run_op("load96", 3'b001, 0, 8'h96, 8'h96, 1'b0);
    idle_check("load96");
    run_op("asr3", 3'b100, 3, 8'h00, 8'hF2, 1'b0);
    run_op("load81", 3'b001, 0, 8'h81, 8'h81, 1'b0);
    run_op("ror7", 3'b110, 7, 8'h00, 8'h03, 1'b0);
    run_op("load96b", 3'b001, 0, 8'h96, 8'h96, 1'b0);
    run_op("rol1", 3'b101, 1, 8'h00, 8'h2D, 1'b0);
    run_op("load96c", 3'b001, 0, 8'h96, 8'h96, 1'b0);
    run_op("lsl2", 3'b010, 2, 8'h00, 8'h58, 1'b0);
    run_op("load96d", 3'b001, 0, 8'h96, 8'h96, 1'b0);
    run_op("lsr0", 3'b011, 0, 8'hFF, 8'h96, 1'b0);
    idle_check("lsr0");
    run_op("lsr3_junk", 3'b011, 3, 8'h00, 8'h12, 1'b1);
    run_op("b2b_load5a", 3'b001, 0, 8'h5A, 8'h5A, 1'b0);
    run_op("rsvd", 3'b111, 3, 8'hFF, 8'h5A, 1'b0);
    run_op("nop", 3'b000, 5, 8'h11, 8'h5A, 1'b0);
    idle_check("nop");

`ifndef SHIFTER_N_BARREL_EN
    run_op("loadf0", 3'b001, 0, 8'hF0, 8'hF0, 1'b0);
    start = 1'b1; op = 3'b011; shamt = SHW'(5);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort d_out", d_out, 8'h00);
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    @(posedge clk); #1;
    check("abort no_done", done, 1'b0);
    check("abort stay_idle", busy, 1'b0);
    $display("[TB] abort lsr5 d_out=0x%02h busy=%0b done=%0b", d_out, busy, done);
    cur = 8'h00;
`endif

    for (int i = 0; i < 20; i++) begin
      ro = 3'($urandom_range(0, 7));
      rs = $urandom_range(0, 7);
      rd = 8'($urandom);
      run_op("rand", ro, rs, rd, model(ro, rs, cur, rd), 1'b0);
    end
    idle_check("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shifter_n.md
SHIFTER_N -- requirements
Module: shifter_n

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; legal values 2..64.
REQ-002 Derived constant SHW = ceil(log2(WIDTH)), shift-amount width; not overridable.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  one clock; reset is synchronous and active-high.
REQ-005 start  input  1  request; sampled only when busy=0.
REQ-006 op  input  3  operation code, sampled with start.
REQ-007 shamt  input  SHW  shift amount 0..WIDTH-1, sampled with start.
REQ-008 d_in  input  WIDTH  load data, sampled with start.
REQ-009 d_out  output  WIDTH  result register, registered.
REQ-010 busy  output  1  high while an iterative shift is in progress.
REQ-011 done  output  1  one-cycle pulse marking completion; registered.

Function
REQ-012 Op codes: 000 NOP, 001 LOAD, 010 LSL, 011 LSR, 100 ASR, 101 ROL, 110 ROR; 111 reserved, treated as NOP.
REQ-013 Shift operand is the current d_out value, not d_in; d_in is used only by LOAD.
REQ-014 LSL/LSR fill with 0; ASR fills with d_out[WIDTH-1]; ROL/ROR wrap bits around.
REQ-015 Accept edge E0: start=1 and busy=0; start while busy=1 is ignored, with no effect on state or outputs.
REQ-016 Single-cycle ops (NOP, LOAD, reserved, any shift with shamt=0): d_out updates at E0; done=1 for the cycle after E0; busy stays 0.
REQ-017 FSM has states IDLE and RUN; busy = (state==RUN).
REQ-018 Iterative shift (shamt=k>0): at E0, go IDLE->RUN, latch op, cnt=k, d_out unchanged.
REQ-019 Iterative shift, continued: edges E1..Ek each apply a 1-bit shift and decrement cnt; at Ek, RUN->IDLE.
REQ-020 Iterative shift, timing: done=1 for the cycle after Ek; busy high for exactly k cycles; total latency k+1 edges.
REQ-021 In the done cycle busy=0, so a new start in that cycle is accepted (back-to-back).
REQ-022 d_out holds its value whenever no op is executing.
REQ-023 Latched op/shamt are immune to input changes during RUN.

Reset
REQ-024 With reset=1 at an edge: d_out=0, done=0, busy=0, state=IDLE, cnt=0; this overrides start.
REQ-025 Reset asserted mid-RUN aborts the operation: no done pulse, partial result discarded (d_out=0).
REQ-026 First start accepted on the first edge with reset=0.

Configuration
REQ-027 Macro SHIFTER_N_BARREL_EN defined: all shifts complete in a single cycle via barrel logic, per REQ-016 timing; busy is constant 0 and the RUN state is not built.
REQ-028 Macro SHIFTER_N_BARREL_EN undefined: shifts with shamt>0 use the iterative 1-bit-per-cycle timing of REQ-018..REQ-020.
REQ-029 Final d_out value is identical in both configurations for any op/shamt/operand.

Structure
REQ-030 Package shifter_pkg holds the op-code constants and the FSM state encoding.
REQ-031 Sub-module shifter_n_unit: combinational, computes next d_out from op, amount and operand (1-bit step or full barrel per macro); shifter_n holds FSM, counter and registers.

Verification (WIDTH=8, iterative build unless noted)
REQ-032 Reset, then LOAD d_in=0x96 -> d_out=0x96 after E0, done pulse 1 cycle, busy never high.
REQ-033 From 0x96, ASR shamt=3 -> busy high 3 cycles, d_out 0xCB,0xE5,0xF2, then done; barrel build: 0xF2 and done after E0.
REQ-034 From 0x81, ROR shamt=7 -> 0x03; from 0x96, ROL 1 -> 0x2D; from 0x96, LSL 2 -> 0x58; from 0x96, LSR 0 -> 0x96 single-cycle.
REQ-035 start held high with LOAD 0x00 during a RUN -> ignored, result unaffected; new start in the done cycle -> accepted.
REQ-036 reset during RUN cycle 2 of LSR 5 -> d_out=0, busy=0, no done pulse.
REQ-037 Op 111 with d_out=0x5A -> d_out stays 0x5A, done pulses.
